// File: rtl/i2c_bus_cond_gen_if.sv
// Command and open-drain line bundle between the I2C control FSM,
// the bus-condition generator and the pad mux.
//   master : control FSM / pad side (drives cmd_valid, cmd, scl_in)
//   slave  : generator side (drives cmd_ready, scl_en, sda_en, status)
`timescale 1ns/1ps
interface i2c_bus_cond_gen_if;
   logic       cmd_valid;
   logic [1:0] cmd;
   logic       cmd_ready;
   logic       scl_in;
   logic       scl_en;
   logic       sda_en;
   logic       busy;
   logic       done;
   logic       err;
   logic       bus_owned;

   modport master (
      output cmd_valid, cmd, scl_in,
      input  cmd_ready, scl_en, sda_en,
      input  busy, done, err, bus_owned
   );

   modport slave (
      input  cmd_valid, cmd, scl_in,
      output cmd_ready, scl_en, sda_en,
      output busy, done, err, bus_owned
   );
endinterface

// File: rtl/i2c_bus_cond_gen.sv
// I2C START / REPEATED START / STOP generator on open-drain enables,
// with half-period phase timing and bus-ownership tracking.
// Ports: clk, reset (async, active-high), bus (i2c_bus_cond_gen_if.slave):
//   cmd_valid/cmd/cmd_ready command handshake, scl_in raw pad level,
//   scl_en/sda_en line enables (0 = drive low), busy, done, err, bus_owned.
// Optional: define CLK_STRETCH_EN for SCL stretch wait plus timeout.
`timescale 1ns/1ps
module i2c_bus_cond_gen #(
   parameter int CLK_HZ      = 100000000,
   parameter int SCL_HZ      = 100000,
   parameter int CNT_W       = 16,
   parameter int STRETCH_MAX = 5000
) (
   input  logic               clk,
   input  logic               reset,
   i2c_bus_cond_gen_if.slave  bus
);

   localparam int HALF = CLK_HZ / (2 * SCL_HZ);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

   if (HALF < 2) begin : g_half_chk
      $error("i2c_bus_cond_gen: HALF must be >= 2");
   end
   if (HALF - 1 > (2 ** CNT_W) - 1) begin : g_cnt_chk
      $error("i2c_bus_cond_gen: CNT_W too small for HALF");
   end
   if (STRETCH_MAX > (2 ** CNT_W) - 1) begin : g_str_chk
      $error("i2c_bus_cond_gen: CNT_W too small for STRETCH_MAX");
   end

   typedef enum logic [2:0] {
      IDLE,
      RS_PREP,
      RS_SCL_HI,
      S_SDA_LO,
      S_SCL_LO,
      P_SCL_LO,
      P_SCL_HI,
      P_SDA_HI
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             scl_q;
   logic             sda_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;
   logic             own_q;

   state_t           succ_d;
   state_t           first_d;
   logic             phase_end;

   // {scl_en, sda_en} presented in each state
   function automatic logic [1:0] lines_f(state_t s, logic own);
      lines_f = 2'b11;
      case (s)
         IDLE:      lines_f = own ? 2'b00 : 2'b11;
         RS_PREP:   lines_f = 2'b01;
         RS_SCL_HI: lines_f = 2'b11;
         S_SDA_LO:  lines_f = 2'b10;
         S_SCL_LO:  lines_f = 2'b00;
         P_SCL_LO:  lines_f = 2'b00;
         P_SCL_HI:  lines_f = 2'b10;
         P_SDA_HI:  lines_f = 2'b11;
         default:   lines_f = 2'b11;
      endcase
   endfunction

   assign phase_end = (cnt_q == LAST);

   // Phase successor; IDLE means the sequence completes
   always_comb begin
      succ_d = IDLE;
      case (state_q)
         RS_PREP:   succ_d = RS_SCL_HI;
         RS_SCL_HI: succ_d = S_SDA_LO;
         S_SDA_LO:  succ_d = S_SCL_LO;
         P_SCL_LO:  succ_d = P_SCL_HI;
         P_SCL_HI:  succ_d = P_SDA_HI;
         default:   succ_d = IDLE;
      endcase
   end

   // First phase of an accepted command; IDLE marks it illegal
   always_comb begin
      first_d = IDLE;
      case (bus.cmd)
         2'b01:   if (!own_q) first_d = S_SDA_LO;
         2'b10:   if (own_q)  first_d = RS_PREP;
         2'b11:   if (own_q)  first_d = P_SCL_LO;
         default: first_d = IDLE;
      endcase
   end

`ifdef CLK_STRETCH_EN
   localparam logic [CNT_W-1:0] STR_LAST = CNT_W'(STRETCH_MAX - 1);

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] str_q;
   logic             wait_hi;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= 2'b00;
      else       sync_q <= {sync_q[0], bus.scl_in};
   end

   // Released SCL not yet seen high: a slave may be stretching
   assign wait_hi = ((state_q == RS_SCL_HI) || (state_q == P_SCL_HI))
                    && !sync_q[1];
`else
   logic unused_scl;
   assign unused_scl = bus.scl_in;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         scl_q   <= 1'b1;
         sda_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         own_q   <= 1'b0;
`ifdef CLK_STRETCH_EN
         str_q   <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
`ifdef CLK_STRETCH_EN
         str_q  <= '0;
`endif
         if (state_q == IDLE) begin
            cnt_q <= '0;
            if (bus.cmd_valid) begin
               if (first_d == IDLE) begin
                  err_q <= 1'b1;
               end else begin
                  state_q        <= first_d;
                  busy_q         <= 1'b1;
                  {scl_q, sda_q} <= lines_f(first_d, own_q);
               end
            end
`ifdef CLK_STRETCH_EN
         end else if (wait_hi) begin
            cnt_q <= '0;
            if (str_q == STR_LAST) begin
               // Stretch timeout: abandon the bus entirely
               state_q        <= IDLE;
               busy_q         <= 1'b0;
               own_q          <= 1'b0;
               err_q          <= 1'b1;
               {scl_q, sda_q} <= 2'b11;
            end else begin
               str_q <= str_q + 1'b1;
            end
`endif
         end else if (!phase_end) begin
            cnt_q <= cnt_q + 1'b1;
         end else begin
            cnt_q   <= '0;
            state_q <= succ_d;
            if (succ_d == IDLE) begin
               // START/RSTART end in S_SCL_LO, STOP in P_SDA_HI
               done_q         <= 1'b1;
               busy_q         <= 1'b0;
               own_q          <= (state_q == S_SCL_LO);
               {scl_q, sda_q} <= lines_f(IDLE, state_q == S_SCL_LO);
            end else begin
               {scl_q, sda_q} <= lines_f(succ_d, own_q);
            end
         end
      end
   end

   assign bus.cmd_ready = (state_q == IDLE);
   assign bus.scl_en    = scl_q;
   assign bus.sda_en    = sda_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.bus_owned = own_q;

endmodule

// File: tb/tb_i2c_bus_cond_gen.sv
// Scoreboard bench for i2c_bus_cond_gen: expected phases and end events
// are queued when a command is driven and checked by a line monitor.
`timescale 1ns/1ps
module tb_i2c_bus_cond_gen;

   localparam int HALF = 500;
   localparam int SMAX = 5000;
`ifdef CLK_STRETCH_EN
   localparam int LAG = 2;
`else
   localparam int LAG = 0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic hold  = 1'b0;
   logic own_m = 1'b0;

   always #5 clk = ~clk;

   i2c_bus_cond_gen_if bus ();
   assign bus.scl_in = bus.scl_en & ~hold;

   i2c_bus_cond_gen #(
      .CLK_HZ(100000000),
      .SCL_HZ(100000),
      .CNT_W(16),
      .STRETCH_MAX(SMAX)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   typedef enum int {K_PH, K_DONE, K_ERR} kind_t;
   typedef struct {
      kind_t k;
      logic  a;
      logic  b;
      logic  o;
      int    len;
   } exp_t;

   exp_t       exp_q[$];
   int         n_run = 0;
   int         n_fail = 0;
   int         run_len = 0;
   int         tot = 0;
   logic [1:0] run_pr = 2'b00;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   function automatic void ph(logic a, logic b, int len);
      exp_q.push_back('{K_PH, a, b, 1'b0, len});
   endfunction

   function automatic void fin(kind_t k, logic a, logic b, logic o,
                               int len);
      exp_q.push_back('{k, a, b, o, len});
   endfunction

   task automatic pop(output exp_t e, output bit ok);
      ok = 1'b0;
      e  = '{K_PH, 1'b0, 1'b0, 1'b0, 0};
      if (exp_q.size() == 0) begin
         chk("sb_pop", exp_q.size(), 1);
      end else begin
         e  = exp_q.pop_front();
         ok = 1'b1;
      end
   endtask

   task automatic close_run();
      exp_t e;
      bit   ok;
      pop(e, ok);
      if (ok) begin
         chk("ph_kind", e.k, K_PH);
         chk("ph_lines", run_pr, {e.a, e.b});
         chk("ph_len", run_len, e.len);
      end
      run_len = 0;
   endtask

   always @(negedge clk) begin
      if (reset) begin
         run_len = 0;
         tot     = 0;
      end else begin
         if (bus.busy) begin
            tot++;
            if (run_len != 0 && {bus.scl_en, bus.sda_en} != run_pr)
               close_run();
            if (run_len == 0) run_pr = {bus.scl_en, bus.sda_en};
            run_len++;
         end
         if (bus.done || bus.err) begin
            exp_t  e;
            bit    ok;
            kind_t ko;
            if (run_len != 0) close_run();
            pop(e, ok);
            if (ok) begin
               ko = bus.done ? K_DONE : K_ERR;
               chk("evt_kind", ko, e.k);
               chk("evt_both", {bus.done, bus.err}, {e.k == K_DONE,
                                                     e.k == K_ERR});
               chk("evt_busy", bus.busy, 0);
               chk("evt_lines", {bus.scl_en, bus.sda_en}, {e.a, e.b});
               chk("evt_owned", bus.bus_owned, e.o);
               chk("evt_cycles", tot, e.len);
            end
            tot = 0;
         end
      end
   end

   task automatic send(logic [1:0] c);
      bus.cmd_valid = 1'b1;
      bus.cmd       = c;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd       = 2'b00;
   endtask

   task automatic wait_sb(int lim);
      for (int i = 0; i < lim; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
         #1;
      end
      chk("sb_drain", exp_q.size(), 0);
   endtask

   task automatic exp_start();
      ph(1'b1, 1'b0, HALF);
      ph(1'b0, 1'b0, HALF);
      fin(K_DONE, 1'b0, 1'b0, 1'b1, 2 * HALF);
   endtask

   task automatic exp_rstart();
      ph(1'b0, 1'b1, HALF);
      ph(1'b1, 1'b1, HALF + LAG);
      ph(1'b1, 1'b0, HALF);
      ph(1'b0, 1'b0, HALF);
      fin(K_DONE, 1'b0, 1'b0, 1'b1, 4 * HALF + LAG);
   endtask

   task automatic exp_stop(int extra);
      ph(1'b0, 1'b0, HALF);
      ph(1'b1, 1'b0, HALF + LAG + extra);
      ph(1'b1, 1'b1, HALF);
      fin(K_DONE, 1'b1, 1'b1, 1'b0, 3 * HALF + LAG + extra);
   endtask

   task automatic bad(logic [1:0] c);
      fin(K_ERR, ~own_m, ~own_m, own_m, 0);
      send(c);
      chk("bad_busy", bus.busy, 0);
      chk("bad_ready", bus.cmd_ready, 1);
      @(posedge clk);
      #1;
      chk("bad_pulse", bus.err, 0);
      wait_sb(10);
   endtask

   task automatic chk_rst(string tag);
      chk({tag, "_scl"}, bus.scl_en, 1);
      chk({tag, "_sda"}, bus.sda_en, 1);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_done"}, bus.done, 0);
      chk({tag, "_err"}, bus.err, 0);
      chk({tag, "_own"}, bus.bus_owned, 0);
      chk({tag, "_rdy"}, bus.cmd_ready, 1);
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd       = 2'b00;
      repeat (3) @(negedge clk);
      #1;
      chk_rst("rst");
      reset = 1'b0;
      @(negedge clk);
      #1;

      bad(2'b11);
      bad(2'b10);
      bad(2'b00);

      exp_start();
      send(2'b01);
      own_m = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      bus.cmd_valid = 1'b1;
      bus.cmd       = 2'b11;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd       = 2'b00;
      wait_sb(3 * HALF);

      bad(2'b01);
      bad(2'b00);

      exp_rstart();
      send(2'b10);
      wait_sb(5 * HALF);

      exp_stop(0);
      send(2'b11);
      own_m = 1'b0;
      wait_sb(4 * HALF);
      chk("idle_lines", {bus.scl_en, bus.sda_en}, 2'b11);

      exp_start();
      send(2'b01);
      own_m = 1'b1;
      wait_sb(3 * HALF);
      exp_rstart();
      send(2'b10);
      repeat (699) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk_rst("midrst");
      exp_q.delete();
      own_m = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      #1;
      chk_rst("postrst");
      exp_start();
      send(2'b01);
      own_m = 1'b1;
      wait_sb(3 * HALF);

`ifdef CLK_STRETCH_EN
      hold = 1'b1;
      exp_stop(300);
      send(2'b11);
      repeat (HALF) @(posedge clk);
      #1;
      repeat (300) @(posedge clk);
      #1;
      hold  = 1'b0;
      own_m = 1'b0;
      wait_sb(4 * HALF);

      exp_start();
      send(2'b01);
      own_m = 1'b1;
      wait_sb(3 * HALF);
      hold = 1'b1;
      ph(1'b0, 1'b0, HALF);
      ph(1'b1, 1'b0, SMAX);
      fin(K_ERR, 1'b1, 1'b1, 1'b0, HALF + SMAX);
      send(2'b11);
      wait_sb(HALF + SMAX + 100);
      own_m = 1'b0;
      hold  = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      chk("to_idle", {bus.scl_en, bus.sda_en, bus.busy}, 3'b110);
`endif

      repeat (5) @(negedge clk);
      chk("sb_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_bus_cond_gen.md
Name: i2c_bus_cond_gen

Overview:
- Parametrised I2C bus-condition generator. It produces START, REPEATED START and STOP on open-drain SCL/SDA enables.
- Each condition uses half-period timing derived from the reference clock and the target SCL rate.
- It sits between the main I2C control FSM (command source) and the open-drain pad mux.
- It tracks bus ownership so that illegal condition sequences are rejected.

Parameters:
- CLK_HZ, 100000000, reference clock frequency in Hz.
- SCL_HZ, 100000, target SCL frequency in Hz. Derived localparam HALF = CLK_HZ/(2*SCL_HZ), which is 500 at the defaults.
- CNT_W, 16, phase counter width. Must hold HALF-1 and STRETCH_MAX.
- STRETCH_MAX, 5000, clock-stretch timeout in clk cycles. Used only with CLK_STRETCH_EN.

Ports:
- clk  in  1  reference clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd  in  2  01=START, 10=RSTART, 11=STOP, 00=illegal.
- cmd_ready  out  1  high only in IDLE.
- scl_in  in  1  raw SCL pad level, used for stretch detection.
- scl_en  out  1  0 = drive low, 1 = release.
- sda_en  out  1  0 = drive low, 1 = release.
- busy  out  1  high while a condition sequence runs.
- done  out  1  one-cycle pulse when a sequence completes.
- err  out  1  one-cycle pulse on an illegal command or a stretch timeout.
- bus_owned  out  1  high between a completed START and a completed STOP.

Behaviour:
- Reset (asynchronous, any state, including mid-sequence): state=IDLE, scl_en=1, sda_en=1, busy=0, done=0, err=0, bus_owned=0, counter=0.
- Handshake:
  - A command is accepted on the rising edge where cmd_valid && cmd_ready.
  - busy rises and the outputs change on that same edge.
  - cmd is sampled once at acceptance and is not sampled again.
- IDLE outputs: bus_owned=0 gives scl_en=1, sda_en=1 (bus released). bus_owned=1 gives scl_en=0, sda_en=0 (SCL held low, bus held).
- Legality:
  - START is legal only when bus_owned=0. RSTART and STOP are legal only when bus_owned=1.
  - cmd=00 is always illegal.
  - An illegal command is consumed: err pulses 1 cycle, the state stays IDLE, and the outputs are unchanged.
- Phase timing: each phase lasts exactly HALF clk cycles. The counter runs 0..HALF-1, the phase exits on HALF-1, and the counter clears on every phase change.
- Phases, listed as (scl_en, sda_en):
  - RS_PREP (0,1)
  - RS_SCL_HI (1,1)
  - S_SDA_LO (1,0)
  - S_SCL_LO (0,0)
  - P_SCL_LO (0,0)
  - P_SCL_HI (1,0)
  - P_SDA_HI (1,1)
- Sequences:
  - START: S_SDA_LO -> S_SCL_LO -> IDLE. Duration 2*HALF. Sets bus_owned.
  - RSTART: RS_PREP -> RS_SCL_HI -> S_SDA_LO -> S_SCL_LO -> IDLE. Duration 4*HALF. bus_owned stays 1.
  - STOP: P_SCL_LO -> P_SCL_HI -> P_SDA_HI -> IDLE. Duration 3*HALF. Clears bus_owned. P_SDA_HI provides the bus-free time.
- Completion: done pulses on the same edge that returns the FSM to IDLE. bus_owned updates on that edge. busy falls on that edge.
- Back-to-back commands: the earliest next acceptance is the edge after done. There is no IDLE bubble beyond that one cycle.
- SDA only changes while SCL is low, except the intentional START/STOP edges in S_SDA_LO and P_SDA_HI.
- cmd_valid while busy is ignored (not queued).
- Elaboration check: HALF >= 2, otherwise $error.

Optional Feature:
- Macro: CLK_STRETCH_EN.
- With the macro defined:
  - scl_in passes through a 2-flop synchroniser.
  - In RS_SCL_HI and P_SCL_HI the phase counter is held at 0 until synced SCL reads 1, so slave stretching extends the phase.
  - A separate stretch counter runs while waiting. If it reaches STRETCH_MAX, err pulses, both lines are released, bus_owned=0, the FSM returns to IDLE and done does not pulse.
- Without the macro: scl_in is ignored, there is no synchroniser or stretch counter, and phases are purely counter-timed.

Test Plan:
1. After reset, assert cmd=01 for 1 cycle. scl_en=1/sda_en=0 for 500 cycles, then 0/0 for 500 cycles. done pulses at cycle 1000, bus_owned=1.
2. After START, send cmd=10. The phases run 0/1, 1/1, 1/0, 0/0 at 500 cycles each. done at 2000 cycles, bus_owned stays 1.
3. After START, send cmd=11. The phases run 0/0, 1/0, 1/1 at 500 cycles each. done at 1500, bus_owned=0, idle outputs 1/1.
4. Illegal commands: STOP with bus_owned=0, START with bus_owned=1, and cmd=00. Each gives a 1-cycle err pulse, outputs unchanged, no busy, no done.
5. Assert reset at cycle 700 of RSTART. All outputs go to reset values immediately, and a new START completes normally.
6. With CLK_STRETCH_EN, hold scl_in=0 for 300 cycles in P_SCL_HI, so STOP completes in 1800 cycles. Holding scl_in=0 for 6000 cycles gives an err pulse at the timeout, lines released, no done.
